// File: rtl/red_pitaya_slowdac_ramp.sv
// red_pitaya_slowdac_ramp
//   Two-channel slew-rate-limited setpoint generator feeding the 14-bit
//   data0_i/data1_i inputs of the AD5689 slow-DAC driver. Each channel
//   walks from its current value toward a software target by at most STEP
//   per prescaled tick, so software can move the slow DACs without jumps.
//
// Ports:
//   clk_i, rst_i         system clock, synchronous active-high reset
//   data0_o, data1_o     channel values, 14-bit two's complement, registered
//   sys_addr/sys_wdata   bus address ([19:0] decoded) and write data
//   sys_sel              byte select, ignored (all writes are full-word)
//   sys_wen/sys_ren      bus write/read strobes
//   sys_rdata/sys_ack    read data and acknowledge, one cycle after strobe
//   sys_err              always 0
//
// Register map (sys_addr[19:0]):
//   0x00 CTRL [1:0] en1,en0     0x04 TARGET0 [13:0]   0x08 TARGET1 [13:0]
//   0x0C STEP0 [13:0]           0x10 STEP1 [13:0]     0x14 PRESC [15:0]
//   0x18 VALUE (RO)             0x1C STATUS (RO) [1:0] busy
//
// Optional feature, macro SLOWDAC_RAMP_LIMIT_EN: LIMIT0/LIMIT1 at 0x20/0x24
// ([13:0] min, [29:16] max) clamp the target at tick time; STATUS[3:2] are
// sticky clamp flags cleared by writing 1 to them.
//
// Bus handshake: a cycle with sys_wen or sys_ren is acknowledged by
// sys_ack=1 in the following cycle for every address; sys_rdata is valid in
// that same ack cycle, and a write is visible from that cycle on.

module red_pitaya_slowdac_ramp #(
  parameter int unsigned PRESC_RST = 124,
  parameter int unsigned STEP_RST  = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [13:0] data0_o,
  output logic [13:0] data1_o,
  input  logic [31:0] sys_addr,
  input  logic [31:0] sys_wdata,
  input  logic [3:0]  sys_sel,
  input  logic        sys_wen,
  input  logic        sys_ren,
  output logic [31:0] sys_rdata,
  output logic        sys_err,
  output logic        sys_ack
);

  localparam logic [19:0] A_CTRL   = 20'h00;
  localparam logic [19:0] A_TGT0   = 20'h04;
  localparam logic [19:0] A_TGT1   = 20'h08;
  localparam logic [19:0] A_STEP0  = 20'h0C;
  localparam logic [19:0] A_STEP1  = 20'h10;
  localparam logic [19:0] A_PRESC  = 20'h14;
  localparam logic [19:0] A_VALUE  = 20'h18;
  localparam logic [19:0] A_STATUS = 20'h1C;

  logic [1:0]  r_ctrl;
  logic [13:0] r_tgt0, r_tgt1, r_step0, r_step1;
  logic [13:0] r_data0, r_data1;
  logic [15:0] r_presc, r_cnt;
  logic        r_ack;
  logic [31:0] r_rdata;

  logic [19:0] w_addr;
  logic        w_tick, w_wr_presc;
  logic        w_en0, w_en1;
  logic [13:0] w_tgt_eff0, w_tgt_eff1;
  logic [13:0] w_next0, w_next1;
  logic [1:0]  w_clamp_rd;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_addr     = sys_addr[19:0];
  assign w_tick     = (r_cnt == r_presc);
  assign w_wr_presc = sys_wen && (w_addr == A_PRESC);
  assign w_unused   = ^{sys_sel, sys_addr[31:20], sys_wdata};

  // One ramp step: the 15-bit difference cannot overflow for 14-bit
  // operands, and landing on the target whenever |diff| <= step is what
  // prevents overshoot (and makes cur +/- step always representable).
  function automatic logic [13:0] f_ramp(input logic [13:0] cur,
                                         input logic [13:0] tgt,
                                         input logic [13:0] step);
    logic [14:0] diff;
    logic [14:0] mag;
    diff = {tgt[13], tgt} - {cur[13], cur};
    mag  = diff[14] ? (15'd0 - diff) : diff;
    if ((step == 14'd0) || (mag <= {1'b0, step})) f_ramp = tgt;
    else if (!diff[14])                          f_ramp = cur + step;
    else                                         f_ramp = cur - step;
  endfunction

`ifdef SLOWDAC_RAMP_LIMIT_EN
  localparam logic [19:0] A_LIM0 = 20'h20;
  localparam logic [19:0] A_LIM1 = 20'h24;

  logic [13:0] r_min0, r_max0, r_min1, r_max1;
  logic [1:0]  r_clamp;
  logic        w_lim_ok0, w_lim_ok1;
  logic [1:0]  w_clamp_set, w_clamp_clr;

  function automatic logic [13:0] f_clamp(input logic [13:0] tgt,
                                          input logic [13:0] mn,
                                          input logic [13:0] mx);
    if ($signed(tgt) < $signed(mn))      f_clamp = mn;
    else if ($signed(tgt) > $signed(mx)) f_clamp = mx;
    else                                 f_clamp = tgt;
  endfunction

  // An inverted window (min > max) freezes the channel like en=0.
  assign w_lim_ok0   = !($signed(r_max0) < $signed(r_min0));
  assign w_lim_ok1   = !($signed(r_max1) < $signed(r_min1));
  assign w_en0       = r_ctrl[0] & w_lim_ok0;
  assign w_en1       = r_ctrl[1] & w_lim_ok1;
  assign w_tgt_eff0  = f_clamp(r_tgt0, r_min0, r_max0);
  assign w_tgt_eff1  = f_clamp(r_tgt1, r_min1, r_max1);
  assign w_clamp_set = {w_tick & w_en1 & (w_tgt_eff1 != r_tgt1),
                        w_tick & w_en0 & (w_tgt_eff0 != r_tgt0)};
  assign w_clamp_clr = (sys_wen && (w_addr == A_STATUS)) ? sys_wdata[3:2] : 2'b00;
  assign w_clamp_rd  = r_clamp;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_min0  <= 14'h2000;
      r_max0  <= 14'h1FFF;
      r_min1  <= 14'h2000;
      r_max1  <= 14'h1FFF;
      r_clamp <= 2'b00;
    end else begin
      if (sys_wen && (w_addr == A_LIM0)) begin
        r_min0 <= sys_wdata[13:0];
        r_max0 <= sys_wdata[29:16];
      end
      if (sys_wen && (w_addr == A_LIM1)) begin
        r_min1 <= sys_wdata[13:0];
        r_max1 <= sys_wdata[29:16];
      end
      // A clamp in the same cycle as a clear wins, so no event is lost.
      r_clamp <= (r_clamp & ~w_clamp_clr) | w_clamp_set;
    end
  end
`else
  assign w_en0      = r_ctrl[0];
  assign w_en1      = r_ctrl[1];
  assign w_tgt_eff0 = r_tgt0;
  assign w_tgt_eff1 = r_tgt1;
  assign w_clamp_rd = 2'b00;
`endif

  assign w_next0 = f_ramp(r_data0, w_tgt_eff0, r_step0);
  assign w_next1 = f_ramp(r_data1, w_tgt_eff1, r_step1);

  always_comb begin
    w_rdata = 32'd0;
    case (w_addr)
      A_CTRL:   w_rdata = {30'd0, r_ctrl};
      A_TGT0:   w_rdata = {18'd0, r_tgt0};
      A_TGT1:   w_rdata = {18'd0, r_tgt1};
      A_STEP0:  w_rdata = {18'd0, r_step0};
      A_STEP1:  w_rdata = {18'd0, r_step1};
      A_PRESC:  w_rdata = {16'd0, r_presc};
      A_VALUE:  w_rdata = {2'd0, r_data1, 2'd0, r_data0};
      A_STATUS: w_rdata = {28'd0, w_clamp_rd, (r_data1 != r_tgt1), (r_data0 != r_tgt0)};
`ifdef SLOWDAC_RAMP_LIMIT_EN
      A_LIM0:   w_rdata = {2'd0, r_max0, 2'd0, r_min0};
      A_LIM1:   w_rdata = {2'd0, r_max1, 2'd0, r_min1};
`endif
      default:  w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ctrl  <= 2'b00;
      r_tgt0  <= 14'd0;
      r_tgt1  <= 14'd0;
      r_step0 <= 14'(STEP_RST);
      r_step1 <= 14'(STEP_RST);
      r_presc <= 16'(PRESC_RST);
      r_cnt   <= 16'd0;
      r_data0 <= 14'd0;
      r_data1 <= 14'd0;
      r_ack   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ack   <= sys_wen | sys_ren;
      r_rdata <= sys_ren ? w_rdata : 32'd0;

      if (sys_wen) begin
        case (w_addr)
          A_CTRL:  r_ctrl  <= sys_wdata[1:0];
          A_TGT0:  r_tgt0  <= sys_wdata[13:0];
          A_TGT1:  r_tgt1  <= sys_wdata[13:0];
          A_STEP0: r_step0 <= sys_wdata[13:0];
          A_STEP1: r_step1 <= sys_wdata[13:0];
          A_PRESC: r_presc <= sys_wdata[15:0];
          default: ;
        endcase
      end

      // Writing PRESC restarts the tick period from zero.
      if (w_wr_presc || w_tick) r_cnt <= 16'd0;
      else                      r_cnt <= r_cnt + 16'd1;

      // Updates use the register values in force during the tick cycle;
      // a write in that same cycle applies from the next tick.
      if (w_tick && w_en0) r_data0 <= w_next0;
      if (w_tick && w_en1) r_data1 <= w_next1;
    end
  end

  assign data0_o   = r_data0;
  assign data1_o   = r_data1;
  assign sys_rdata = r_rdata;
  assign sys_ack   = r_ack;
  assign sys_err   = 1'b0;

endmodule

// File: doc/red_pitaya_slowdac_ramp.md
Name: red_pitaya_slowdac_ramp

Overview:
Two-channel, bus-programmable, slew-rate-limited setpoint generator.
It drives the 14-bit data0_i/data1_i inputs of the AD5689 slow-DAC driver, so its outputs are 14-bit two's complement.
Each channel walks from its current value toward a software target in fixed steps, at a prescaled tick rate.
Software moves the slow DACs without output jumps, and can poll for ramp completion.

Parameters:
PRESC_RST, 124, prescaler reset value (tick every PRESC_RST+1 clk_i cycles; 1 us at 125 MHz)
STEP_RST, 0, reset value of both step registers (0 = jump)

Ports:
clk_i  in  1  system clock, 125 MHz
rst_i  in  1  synchronous reset, active-high
data0_o  out  14  channel 0 value, two's complement, registered
data1_o  out  14  channel 1 value, two's complement, registered
sys_addr  in  32  bus address; [19:0] decoded
sys_wdata  in  32  bus write data
sys_sel  in  4  byte select; ignored, all writes are full-word
sys_wen  in  1  bus write strobe
sys_ren  in  1  bus read strobe
sys_rdata  out  32  bus read data
sys_err  out  1  bus error; always 0
sys_ack  out  1  bus acknowledge

Behaviour:
- Reset (rst_i=1 at clk_i edge): data0_o=data1_o=0, targets=0, steps=STEP_RST, prescaler=PRESC_RST, ctrl=0, tick counter=0, sys_ack=0, sys_err=0, sys_rdata=0. Reset mid-ramp aborts immediately; no state survives.
- Register map, sys_addr[19:0] (W = write, R = read):
  - 0x00 CTRL, RW: [0] en0, [1] en1.
  - 0x04 TARGET0, RW: [13:0] signed.
  - 0x08 TARGET1, RW: [13:0] signed.
  - 0x0C STEP0, RW: [13:0] unsigned.
  - 0x10 STEP1, RW: [13:0] unsigned.
  - 0x14 PRESC, RW: [15:0].
  - 0x18 VALUE, RO: [13:0]=data0_o, [29:16]=data1_o.
  - 0x1C STATUS, RO: [0] busy0, [1] busy1; busyN = (dataN_o != TARGETN).
  - Unused write bits are ignored. Unused read bits, and reads of unmapped addresses, return 0. Writes to RO or unmapped addresses have no effect.
- Bus handshake: sys_ack=1 in the cycle after any cycle with sys_wen|sys_ren, for every address, else 0.
  - sys_rdata is valid in the same cycle as sys_ack.
  - A register write takes effect in the cycle after sys_wen.
- Tick generator:
  - The 16-bit counter counts 0..PRESC; tick=1 in the cycle the counter equals PRESC, then the counter wraps to 0.
  - PRESC=0 gives a tick every cycle.
  - A write to PRESC clears the counter.
- Per-channel update: evaluated on each tick, and only when enN=1.
  - Compute diff = TARGET - data, 15-bit signed, with no overflow possible.
  - If STEP=0 or |diff| <= STEP: data <= TARGET, so the ramp never overshoots.
  - Else if diff>0: data <= data + STEP.
  - Else: data <= data - STEP.
  - The output updates in the cycle after the tick; both channels are independent.
- enN=0: dataN_o holds its value. TARGET/STEP remain writable; on re-enable the ramp resumes from the held value.
- Target written mid-ramp: the next tick steps from the current dataN_o toward the new target; no restart, no jump.
- A bus write landing in the same cycle as a tick: the tick uses the old register value, and the new value applies from the following tick.
- The accumulator-free datapath keeps data0_o/data1_o static between ticks.

Optional Feature:
- Macro: SLOWDAC_RAMP_LIMIT_EN.
- With the macro defined:
  - Adds registers 0x20 LIMIT0 ([13:0] min, [29:16] max, signed) and 0x24 LIMIT1, same layout.
  - Reset values: min=-8192, max=8191.
  - The effective target is the written TARGET clamped to [min,max]; the clamp is applied at tick evaluation.
  - If dataN_o is outside the limits, the channel ramps into range at STEP per tick.
  - STATUS[2]/[3]: sticky clampN flag, set whenever a clamp was applied; cleared by writing 1 to that bit of 0x1C.
  - If min>max, the channel holds its value (treated as enN=0).
- Without the macro:
  - 0x20/0x24 read 0, and writes to them are ignored.
  - STATUS[3:2] read 0.
  - No clamp logic is synthesised.

Test Plan:
- Jump: PRESC=0, STEP0=100, TARGET0=1000, CTRL=1 -> data0_o = 100,200,...,1000 on successive cycles; STATUS[0] reads 0 after the 10th tick; data1_o stays 0.
- No overshoot: STEP0=300, TARGET0=1000 -> 300,600,900,1000; stays 1000.
- Negative/full-scale: data0_o=0, STEP0=8191, TARGET0=-8192 -> -8191 then -8192; no wrap to a positive value.
- Prescale plus retarget: PRESC=3, STEP0=10, TARGET0=100.
  - data0_o changes exactly every 4 cycles.
  - Writing TARGET0=20 when data0_o=50 gives 40,30,20.
- Disable/reset: clear en0 mid-ramp at 60 -> holds 60 for 100 cycles; set en0 -> resumes 70.
  - Asserting rst_i mid-ramp gives data0_o=0 and PRESC=124 next cycle.
- Bus: read 0x18 with data0_o=5, data1_o=-1 -> sys_rdata=0x3FFF0005 with sys_ack one cycle after sys_ren; unmapped read 0x40 -> 0, ack, sys_err=0.
- (Macro on) LIMIT0 = {max=500, min=-500}, TARGET0=2000, STEP0=0 -> data0_o=500, STATUS[2]=1; writing 0x4 to 0x1C clears STATUS[2].
